// File: rtl/seq_mac_multiplier.sv
// ---------------------------------------------------------------------------
// seq_mac_multiplier
//
// Shift-add sequential multiplier with an accumulator behind it. A start in
// IDLE captures both operands. WIDTH add-and-shift iterations then build the
// product. A single DONE cycle publishes the product on mult_out_o and can
// add it into a wide accumulator that has a sticky overflow flag.
//
// Optional build macro: SEQ_MAC_SIGNED_EN
//   Adds signed_mode_i, which is captured with start. In signed mode the core
//   multiplies operand magnitudes. The product is negated in DONE when the
//   operand signs differ. It is then sign-extended into the accumulator, and
//   acc_ovf_o reports two's-complement overflow.
//
// Ports
//   clk_i          system clock, rising edge
//   reset_ni       asynchronous reset, active low
//   start_i        request a multiply (sampled only in IDLE)
//   a_in_i/b_in_i  multiplicand / multiplier, captured on accepted start
//   acc_en_i       captured with start: accumulate the product at completion
//   acc_clr_i      synchronous accumulator + overflow clear
//   signed_mode_i  (SEQ_MAC_SIGNED_EN only) two's-complement operands
//   busy_o         from one cycle after acceptance through the done cycle
//   done_o         one-cycle result-valid pulse
//   mult_out_o     last completed product, held until the next completion
//   acc_out_o      accumulator value
//   acc_ovf_o      sticky accumulator overflow
// ---------------------------------------------------------------------------
module seq_mac_multiplier #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+4
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   start_i,
    input  logic [WIDTH-1:0]       a_in_i,
    input  logic [WIDTH-1:0]       b_in_i,
    input  logic                   acc_en_i,
    input  logic                   acc_clr_i,
`ifdef SEQ_MAC_SIGNED_EN
    input  logic                   signed_mode_i,
`endif
    output logic                   busy_o,
    output logic                   done_o,
    output logic [2*WIDTH-1:0]     mult_out_o,
    output logic [ACC_WIDTH-1:0]   acc_out_o,
    output logic                   acc_ovf_o
);

    localparam int PW    = 2*WIDTH;
    localparam int CNT_W = $clog2(WIDTH+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [PW-1:0]          prod_q, prod_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   acc_en_q, acc_en_d;
    logic                   sgn_q, sgn_d;
    logic                   neg_q, neg_d;
    logic [PW-1:0]          mult_q, mult_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   sgn_in;
`ifdef SEQ_MAC_SIGNED_EN
    assign sgn_in = signed_mode_i;
`else
    assign sgn_in = 1'b0;
`endif

    // In signed mode the core only ever sees magnitudes. -2^(WIDTH-1) maps to
    // 2^(WIDTH-1), which still fits as a WIDTH-bit unsigned value.
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = (sgn_in && a_in_i[WIDTH-1]) ? (~a_in_i + WIDTH'(1)) : a_in_i;
    assign b_mag = (sgn_in && b_in_i[WIDTH-1]) ? (~b_in_i + WIDTH'(1)) : b_in_i;

    // One iteration: conditional add into the upper half (the carry is kept),
    // then shift {carry, upper, lower} right by one.
    logic [WIDTH:0] step_sum;
    assign step_sum = {1'b0, prod_q[PW-1:WIDTH]}
                    + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};

    // Final product with the sign restored.
    logic [PW-1:0] res;
    assign res = neg_q ? (~prod_q + PW'(1)) : prod_q;

    // A clear in the same cycle as an accumulate means "clear, then add". A
    // zero base covers that case and cannot report an overflow.
    logic [ACC_WIDTH-1:0] acc_base, addend;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 ovf_now;
    assign acc_base = acc_clr_i ? '0 : acc_q;
    assign addend   = sgn_q ? ACC_WIDTH'($signed(res)) : ACC_WIDTH'(res);
    assign acc_sum  = {1'b0, acc_base} + {1'b0, addend};
    assign ovf_now  = sgn_q ? ((acc_base[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                               (acc_sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]))
                            : acc_sum[ACC_WIDTH];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Datapath and registered outputs
    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        acc_en_d = acc_en_q;
        sgn_d    = sgn_q;
        neg_d    = neg_q;
        mult_d   = mult_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        // busy/done are registered from the state. They trail it by one
        // cycle, so the done pulse lines up with the freshly written mult_out.
        busy_d   = (state_q != IDLE);
        done_d   = (state_q == DONE);
        case (state_q)
            IDLE: if (start_i) begin
                mcand_d  = a_mag;
                prod_d   = {{WIDTH{1'b0}}, b_mag};
                cnt_d    = CNT_W'(WIDTH);
                acc_en_d = acc_en_i;
                sgn_d    = sgn_in;
                neg_d    = sgn_in & (a_in_i[WIDTH-1] ^ b_in_i[WIDTH-1]);
            end
            RUN: begin
                prod_d = {step_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q - CNT_W'(1);
            end
            DONE:    mult_d = res;
            default: ;
        endcase
        if (acc_clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
        if (state_q == DONE && acc_en_q) begin
            acc_d = acc_sum[ACC_WIDTH-1:0];
            ovf_d = ovf_d | ovf_now;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            acc_en_q <= 1'b0;
            sgn_q    <= 1'b0;
            neg_q    <= 1'b0;
            mult_q   <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            acc_en_q <= acc_en_d;
            sgn_q    <= sgn_d;
            neg_q    <= neg_d;
            mult_q   <= mult_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign mult_out_o = mult_q;
    assign acc_out_o  = acc_q;
    assign acc_ovf_o  = ovf_q;

endmodule

// File: tb/tb_seq_mac_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_mac_multiplier
//
// Two instances (ACC_WIDTH 20 and 17) share one stimulus stream. A reference
// model computes products and accumulator values with plain integer
// arithmetic. Directed steps follow the test plan, and a randomized sweep
// comes after them.
// ---------------------------------------------------------------------------
module tb_seq_mac_multiplier;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        acc_en = 1'b0;
    logic        acc_clr = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
`ifdef SEQ_MAC_SIGNED_EN
    logic        sm = 1'b0;
`endif

    logic        busy, done, ovf, busy17, done17, ovf17;
    logic [15:0] mult, mult17;
    logic [19:0] acc;
    logic [16:0] acc17;

    seq_mac_multiplier #(.WIDTH(W), .ACC_WIDTH(20)) dut (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start), .a_in_i(a), .b_in_i(b),
        .acc_en_i(acc_en), .acc_clr_i(acc_clr),
`ifdef SEQ_MAC_SIGNED_EN
        .signed_mode_i(sm),
`endif
        .busy_o(busy), .done_o(done), .mult_out_o(mult), .acc_out_o(acc),
        .acc_ovf_o(ovf));

    seq_mac_multiplier #(.WIDTH(W), .ACC_WIDTH(17)) dut17 (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start), .a_in_i(a), .b_in_i(b),
        .acc_en_i(acc_en), .acc_clr_i(acc_clr),
`ifdef SEQ_MAC_SIGNED_EN
        .signed_mode_i(sm),
`endif
        .busy_o(busy17), .done_o(done17), .mult_out_o(mult17), .acc_out_o(acc17),
        .acc_ovf_o(ovf17));

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int fail_cnt = 0;

    longint m_acc20 = 0, m_acc17 = 0;
    bit     m_ovf20 = 0, m_ovf17 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Accumulator reference: an integer kept modulo 2^aw, with overflow taken
    // from the range of the true (unbounded) sum.
    task automatic model_acc(input int aw, inout longint macc, inout bit movf,
                             input longint p, input bit sgn, input bit en, input bit clr);
        longint lim, sa, s;
        lim = longint'(1) << aw;
        if (clr) begin macc = 0; movf = 0; end
        if (en) begin
            if (!sgn) begin
                s = macc + p;
                if (s >= lim) movf = 1;
                macc = s % lim;
            end else begin
                sa = (macc >= lim/2) ? macc - lim : macc;
                s  = sa + p;
                if (s < -(lim/2) || s >= lim/2) movf = 1;
                macc = ((s % lim) + lim) % lim;
            end
        end
    endtask

    task automatic model_reset();
        m_acc20 = 0; m_acc17 = 0; m_ovf20 = 0; m_ovf17 = 0;
    endtask

    task automatic chk_accs(input string tag);
        chk({tag, "_acc20"}, 64'(acc),   64'(m_acc20));
        chk({tag, "_ovf20"}, 64'(ovf),   64'(m_ovf20));
        chk({tag, "_acc17"}, 64'(acc17), 64'(m_acc17));
        chk({tag, "_ovf17"}, 64'(ovf17), 64'(m_ovf17));
    endtask

    // One multiply. clr asserts acc_clr on the completing edge. poke re-asserts
    // start with other operands while the operation is in RUN.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input bit en,
                         input bit clr, input bit sgn, input bit poke, input string tag);
        longint      p;
        int          done_at, busy_n, done_n;
        logic [63:0] exp_m;
        done_at = 0; busy_n = 0; done_n = 0;
        if (sgn) p = longint'($signed(oa)) * longint'($signed(ob));
        else     p = longint'(oa) * longint'(ob);
        exp_m = 64'(p) & 64'hFFFF;
        model_acc(20, m_acc20, m_ovf20, p, sgn, en, clr);
        model_acc(17, m_acc17, m_ovf17, p, sgn, en, clr);

        a = oa; b = ob; acc_en = en; start = 1'b1;
`ifdef SEQ_MAC_SIGNED_EN
        sm = sgn;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        a = oa ^ 8'h5A; b = ob ^ 8'hA5; acc_en = ~en;
`ifdef SEQ_MAC_SIGNED_EN
        sm = ~sgn;
`endif
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            acc_clr = clr && (c == 8);
            start   = poke && (c == 3);
            @(negedge clk);
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = c;
            end
            if (busy) busy_n++;
            if (c == 9) begin
                chk({tag, "_mult"},  64'(mult),   exp_m);
                chk({tag, "_mult17"}, 64'(mult17), exp_m);
                chk({tag, "_done17"}, 64'(done17), 64'd1);
                chk_accs(tag);
            end
        end
        chk({tag, "_done_at"}, 64'(done_at), 64'd9);
        chk({tag, "_done_n"},  64'(done_n),  64'd1);
        chk({tag, "_busy_n"},  64'(busy_n),  64'd9);
    endtask

    task automatic clear_acc(input string tag);
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        model_acc(20, m_acc20, m_ovf20, 0, 0, 0, 1);
        model_acc(17, m_acc17, m_ovf17, 0, 0, 0, 1);
        @(negedge clk);
        chk_accs(tag);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit           rs;
        int           seen_done;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mult", 64'(mult), 64'd0);
        chk_accs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // basic product and timing
        do_op(8'd13, 8'd11, 0, 0, 0, 0, "m13x11");
        chk("plan_143", 64'(mult), 64'd143);
        do_op(8'd255, 8'd255, 0, 0, 0, 0, "m255x255");
        chk("plan_fe01", 64'(mult), 64'hFE01);
        do_op(8'd0, 8'd200, 0, 0, 0, 0, "m0x200");

        // accumulate sequence
        clear_acc("clr1");
        do_op(8'd10, 8'd10, 1, 0, 0, 0, "acc10x10");
        do_op(8'd20, 8'd3,  1, 0, 0, 0, "acc20x3");
        do_op(8'd7,  8'd7,  1, 0, 0, 0, "acc7x7");
        chk("plan_209", 64'(acc), 64'd209);
        chk("plan_209_ovf", 64'(ovf), 64'd0);
        do_op(8'd5, 8'd5, 1, 1, 0, 0, "clr_at_done");
        chk("plan_25", 64'(acc), 64'd25);

        // 17-bit accumulator overflow
        clear_acc("clr2");
        for (int i = 0; i < 3; i++) do_op(8'd255, 8'd255, 1, 0, 0, 0, "ovf17");
        chk("plan_64003", 64'(acc17), 64'd64003);
        chk("plan_ovf17", 64'(ovf17), 64'd1);
        clear_acc("clr3");

        // start during RUN is ignored
        do_op(8'd6, 8'd7, 0, 0, 0, 1, "poke");
        chk("plan_42", 64'(mult), 64'd42);

        // reset in the middle of RUN
        do_op(8'd9, 8'd9, 1, 0, 0, 0, "pre_rst");
        a = 8'd20; b = 8'd30; acc_en = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_mult", 64'(mult), 64'd0);
        chk_accs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || done17) seen_done++;
        end
        chk("midrst_no_done", 64'(seen_done), 64'd0);
        chk("midrst_mult_hold", 64'(mult), 64'd0);

`ifdef SEQ_MAC_SIGNED_EN
        do_op(8'h80, 8'h80, 0, 0, 1, 0, "s_m128sq");
        chk("plan_16384", 64'(mult), 64'd16384);
        do_op(8'hFD, 8'd5, 0, 0, 1, 0, "s_m3x5");
        chk("plan_fff1", 64'(mult), 64'hFFF1);
        clear_acc("clr_s");
        do_op(8'hFD, 8'd5, 1, 0, 1, 0, "s_acc_neg");
        do_op(8'd3,  8'd5, 1, 0, 1, 0, "s_acc_pos");
        chk("plan_s_zero", 64'(acc), 64'd0);
        chk("plan_s_ovf",  64'(ovf), 64'd0);
`endif

        // randomized sweep
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 8'd0;
                1:       ra = 8'd255;
                2:       ra = 8'h80;
                default: ra = 8'($urandom);
            endcase
            rb = 8'($urandom);
`ifdef SEQ_MAC_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            do_op(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), rs,
                  ($urandom_range(0, 3) == 0), "rnd");
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
